wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Registered, parametrised write-back stage for the RV32I pipeline core. It accepts one instruction per cycle from the MEM stage over a valid/ready handshake and waits in a dedicated state for multi-cycle load data. Load data is aligned and sign- or zero-extended per `funct3`, and the block drives a single-cycle active-low register-file write. A retired-instruction counter provides the `instret` source.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `CNT_W`, 64: width of the retired-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  MEM stage presents an instruction.
- `in_ready`  out  1  stage can accept; combinational, equals (state == IDLE).
- `opcode`  in  7  RV opcode of the presented instruction.
- `funct3`  in  3  load width/sign select; ignored for non-loads.
- `rd`  in  5  destination register index.
- `c`  in  XLEN  ALU result; for loads, the effective address.
- `pc`  in  XLEN  instruction PC.
- `d`  in  XLEN  raw aligned load word from data memory.
- `d_valid`  in  1  `d` is valid this cycle.
- `write_n`  out  1  register-file write enable, active-low, registered.
- `wr_addr`  out  5  register-file write index, registered.
- `data_to_reg`  out  XLEN  register-file write data, registered.
- `retired`  out  CNT_W  count of completed instructions.
- `busy`  out  1  high while in WAIT_LOAD.

## Operation
- The FSM has two states, IDLE and WAIT_LOAD. Acceptance occurs when `in_valid && in_ready`.
- Write data by opcode class:
  - LUI 0110111, AUIPC 0010111, OP-IMM 0010011, OP 0110011: write `c`.
  - JAL 1101111, JALR 1100111: write `pc + 4`, computed modulo 2^XLEN.
  - LOAD 0000011: write the extended load value.
  - BRANCH 1100011, STORE 0100011, and any other opcode: no write.
- The write is suppressed (`write_n` stays 1) when `rd == 0`, for no-write opcodes, and for illegal load `funct3`.
- Load extraction:
  - Byte offset `off = c[log2(XLEN/8)-1:0]`. Select byte or halfword field `d >> (8*off)`, truncated to the access size.
  - 000 LB and 001 LH: sign-extend. 100 LBU and 101 LHU: zero-extend. 010 LW: sign-extend when XLEN=64, pass through when XLEN=32.
  - 110 LWU and 011 LD are legal only when XLEN=64. 111, and 110/011 at XLEN=32, are illegal.
  - Misaligned offsets are not trapped; the field is taken from whatever bytes lie at `off`, and any bits above XLEN read as 0.
- Non-load accepted in IDLE: the write (or no-write) retires on the next edge, and the state stays IDLE.
- Load accepted in IDLE with `d_valid` = 1 in the same cycle: completes exactly like a non-load.
- Load accepted in IDLE with `d_valid` = 0:
  - Latch `funct3`, `rd`, and `off`, then move to WAIT_LOAD.
  - In WAIT_LOAD, `in_ready` = 0 and `in_valid` is ignored.
  - On the first `d_valid` = 1, sample `d`, perform the write on that edge, and return to IDLE.
- `d_valid` in IDLE without an accepted load is ignored.
- Every completed instruction increments `retired` by 1, including no-write instructions and instructions with `rd == 0`. The counter wraps modulo 2^CNT_W.
- `data_to_reg` and `wr_addr` hold their last values while `write_n` = 1.

## Timing
- Reset values: state IDLE, `write_n` = 1, `wr_addr` = 0, `data_to_reg` = 0, `retired` = 0. Consequently `busy` = 0 and `in_ready` = 1 after reset.
- Reset asserted in WAIT_LOAD abandons the load: no write occurs and `retired` does not count it.
- Reset has priority over acceptance and `d_valid` in the same cycle.
- Latency, non-load or load with immediate data: accepted in cycle N, `write_n` = 0 during cycle N+1 only.
- Latency, load with data arriving at cycle N+k (k ≥ 1): write visible during cycle N+k+1. `in_ready` is low during cycles N+1 … N+k, and is high again in cycle N+k+1.
- Back-to-back accepts produce consecutive single-cycle write pulses. `write_n` never stays low without a new completion.
- `retired` updates on the same edge that registers the write.

## Test plan
- Reset, then `c`=1, `pc`=4, `rd`=3, accepting LUI, AUIPC, JAL, JALR, BRANCH, STORE, OP-IMM, OP back-to-back -> `write_n` per cycle 0,0,0,0,1,1,0,0. `data_to_reg` = 1,1,8,8 with the value 8 held through the BRANCH/STORE cycles, then 1,1. `retired` = 8.
- LB, `c`=32'h2, `d`=32'h0080_0000, `d_valid`=1 -> `data_to_reg` = 32'hFFFF_FF80 one cycle later. The same access with LBU -> 32'h0000_0080.
- LH accepted with `d_valid`=0, data arrives 3 cycles later with `d`=32'h8001_0000 and `c[1:0]`=2 -> `busy`/`in_ready` = 1/0 for 3 cycles, then write 32'hFFFF_8001. `retired` +1.
- Reset asserted during WAIT_LOAD -> `write_n` stays 1, `retired` = 0, `in_ready` = 1 the next cycle.
- OP with `rd`=0 -> `write_n` stays 1 and `retired` increments. At XLEN=32, LOAD with `funct3`=110 -> no write.
- XLEN=64, LW, `d`=64'h0000_0000_8000_0000, `off`=0 -> `data_to_reg` = 64'hFFFF_FFFF_8000_0000. With LWU -> 64'h0000_0000_8000_0000.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Write-back stage: retires one instruction per cycle, waits for late load data,
// aligns/extends loads and drives a registered active-low register-file write.
module wb_commit_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic [XLEN-1:0]  c,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  d,
    input  logic             d_valid,
    output logic             write_n,
    output logic [4:0]       wr_addr,
    output logic [XLEN-1:0]  data_to_reg,
    output logic [CNT_W-1:0] retired,
    output logic             busy
);

    localparam int OFF_W = $clog2(XLEN / 8);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    logic [0:0]       state;
    logic [2:0]       funct3_p0;
    logic [4:0]       rd_p0;
    logic [OFF_W-1:0] off_p0;

    logic             accept;
    logic             is_load;
    logic             cls_write;
    logic [XLEN-1:0]  wdata;
    logic             wait_we;
    logic [XLEN-1:0]  wait_data;

    // LWU and LD only exist on the 64-bit datapath.
    function automatic logic load_legal(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            3'b110, 3'b011:                         return (XLEN == 64);
            default:                                return 1'b0;
        endcase
    endfunction

    // Field is taken at the byte offset even when misaligned; bits shifted in from above read as 0.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0]  word,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [2:0]       f3);
        logic [XLEN-1:0]    field;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        field = word >> {off, 3'b000};
        b     = field[7:0];
        h     = field[15:0];
        w     = field[31:0];
        case (f3)
            3'b000:  return XLEN'(b);
            3'b001:  return XLEN'(h);
            3'b010:  return XLEN'(w);
            3'b100:  return XLEN'(field[7:0]);
            3'b101:  return XLEN'(field[15:0]);
            3'b110:  return XLEN'(field[31:0]);
            3'b011:  return field;
            default: return '0;
        endcase
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_load   = (opcode == OP_LOAD);
        cls_write = 1'b0;
        wdata     = c;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP: cls_write = 1'b1;
            OP_JAL, OP_JALR: begin
                cls_write = 1'b1;
                wdata     = pc + XLEN'(4);
            end
            OP_LOAD: begin
                cls_write = load_legal(funct3);
                wdata     = load_extend(d, c[OFF_W-1:0], funct3);
            end
            default: cls_write = 1'b0;
        endcase
    end

    assign wait_we   = load_legal(funct3_p0) && (rd_p0 != 5'd0);
    assign wait_data = load_extend(d, off_p0, funct3_p0);

    // Stage p0: load context held across WAIT_LOAD
    always_ff @(posedge clk) begin
        if (accept && is_load && !d_valid) begin
            funct3_p0 <= funct3;
            rd_p0     <= rd;
            off_p0    <= c[OFF_W-1:0];
        end
    end

    // Stage p1: registered write port and retire count
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            write_n     <= 1'b1;
            wr_addr     <= '0;
            data_to_reg <= '0;
            retired     <= '0;
        end else begin
            write_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load && !d_valid) begin
                            state <= WAIT_LOAD;
                        end else begin
                            retired <= retired + CNT_W'(1);
                            if (cls_write && rd != 5'd0) begin
                                write_n     <= 1'b0;
                                wr_addr     <= rd;
                                data_to_reg <= wdata;
                            end
                        end
                    end
                end
                default: begin
                    if (d_valid) begin
                        state   <= IDLE;
                        retired <= retired + CNT_W'(1);
                        if (wait_we) begin
                            write_n     <= 1'b0;
                            wr_addr     <= rd_p0;
                            data_to_reg <= wait_data;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: a 32-bit and a 64-bit instance share stimulus
// but have separate in_valid lines; every write pulse is matched against a queue.
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_valid64;
    logic        d_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [63:0] c;
    logic [63:0] pc;
    logic [63:0] d;

    logic        in_ready32, write_n32, busy32;
    logic [4:0]  wr_addr32;
    logic [31:0] data32;
    logic [63:0] retired32;

    logic        in_ready64, write_n64, busy64;
    logic [4:0]  wr_addr64;
    logic [63:0] data64;
    logic [63:0] retired64;

    int tests_run = 0;
    int failed    = 0;

    logic [4:0]  qa32[$];
    logic [31:0] qd32[$];
    logic [4:0]  qa64[$];
    logic [63:0] qd64[$];

    logic [4:0]  ea32, ea64;
    logic [31:0] ed32;
    logic [63:0] ed64;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BRANCH = 7'b1100011, STORE = 7'b0100011,
                           OPIMM = 7'b0010011, OP = 7'b0110011, LOAD = 7'b0000011;

    wb_commit_stage #(.XLEN(32), .CNT_W(64)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .opcode(opcode), .funct3(funct3), .rd(rd), .c(c[31:0]), .pc(pc[31:0]),
        .d(d[31:0]), .d_valid(d_valid), .write_n(write_n32), .wr_addr(wr_addr32),
        .data_to_reg(data32), .retired(retired32), .busy(busy32)
    );

    wb_commit_stage #(.XLEN(64), .CNT_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .opcode(opcode), .funct3(funct3), .rd(rd), .c(c), .pc(pc),
        .d(d), .d_valid(d_valid), .write_n(write_n64), .wr_addr(wr_addr64),
        .data_to_reg(data64), .retired(retired64), .busy(busy64)
    );

    always @(negedge clk) begin
        if (rst === 1'b0 && write_n32 === 1'b0) begin
            tests_run++;
            if (qd32.size() == 0) begin
                failed++;
                $display("FAIL mon32_spurious got addr=%0d data=%h want no write", wr_addr32, data32);
            end else begin
                ea32 = qa32.pop_front();
                ed32 = qd32.pop_front();
                if (wr_addr32 !== ea32 || data32 !== ed32) begin
                    failed++;
                    $display("FAIL mon32_write got addr=%0d data=%h want addr=%0d data=%h",
                             wr_addr32, data32, ea32, ed32);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && write_n64 === 1'b0) begin
            tests_run++;
            if (qd64.size() == 0) begin
                failed++;
                $display("FAIL mon64_spurious got addr=%0d data=%h want no write", wr_addr64, data64);
            end else begin
                ea64 = qa64.pop_front();
                ed64 = qd64.pop_front();
                if (wr_addr64 !== ea64 || data64 !== ed64) begin
                    failed++;
                    $display("FAIL mon64_write got addr=%0d data=%h want addr=%0d data=%h",
                             wr_addr64, data64, ea64, ed64);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_valid64 = 1'b0; d_valid = 1'b0;
        opcode = '0; funct3 = '0; rd = '0; c = '0; pc = '0; d = '0;
        step(); step();
        rst = 1'b0;
        tests_run++;
        if (write_n32 !== 1'b1 || wr_addr32 !== 5'd0 || data32 !== 32'd0) begin
            failed++;
            $display("FAIL reset_port got wn=%b addr=%0d data=%h want wn=1 addr=0 data=0",
                     write_n32, wr_addr32, data32);
        end
        tests_run++;
        if (retired32 !== 64'd0 || busy32 !== 1'b0 || in_ready32 !== 1'b1) begin
            failed++;
            $display("FAIL reset_ctrl got ret=%0d busy=%b rdy=%b want ret=0 busy=0 rdy=1",
                     retired32, busy32, in_ready32);
        end
        tests_run++;
        if (write_n64 !== 1'b1 || data64 !== 64'd0 || retired64 !== 64'd0 || in_ready64 !== 1'b1) begin
            failed++;
            $display("FAIL reset_64 got wn=%b data=%h ret=%0d rdy=%b want 1,0,0,1",
                     write_n64, data64, retired64, in_ready64);
        end
    endtask

    task automatic test_opclass();
        logic [6:0]  ops[8]   = '{LUI, AUIPC, JAL, JALR, BRANCH, STORE, OPIMM, OP};
        logic        exp_wn[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_d[8]  = '{32'd1, 32'd1, 32'd8, 32'd8, 32'd8, 32'd8, 32'd1, 32'd1};
        c = 64'd1; pc = 64'd4; rd = 5'd3; funct3 = 3'd0; d_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            opcode   = ops[i];
            in_valid = 1'b1;
            if (!exp_wn[i]) begin
                qa32.push_back(5'd3);
                qd32.push_back(exp_d[i]);
            end
            step();
            tests_run++;
            if (write_n32 !== exp_wn[i] || data32 !== exp_d[i]) begin
                failed++;
                $display("FAIL opclass[%0d] got wn=%b data=%h want wn=%b data=%h",
                         i, write_n32, data32, exp_wn[i], exp_d[i]);
            end
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (write_n32 !== 1'b1 || retired32 !== 64'd8) begin
            failed++;
            $display("FAIL opclass_end got wn=%b ret=%0d want wn=1 ret=8", write_n32, retired32);
        end
        tests_run++;
        if (qd32.size() != 0) begin
            failed++;
            $display("FAIL opclass_queue got %0d pending want 0", qd32.size());
        end
    endtask

    task automatic test_load_imm();
        opcode = LOAD; rd = 5'd5; c = 64'h2; d = 64'h0080_0000; d_valid = 1'b1;
        funct3 = 3'b000; in_valid = 1'b1;
        qa32.push_back(5'd5); qd32.push_back(32'hFFFF_FF80);
        step();
        tests_run++;
        if (write_n32 !== 1'b0 || data32 !== 32'hFFFF_FF80) begin
            failed++;
            $display("FAIL lb got wn=%b data=%h want wn=0 data=ffffff80", write_n32, data32);
        end
        funct3 = 3'b100;
        qa32.push_back(5'd5); qd32.push_back(32'h0000_0080);
        step();
        tests_run++;
        if (write_n32 !== 1'b0 || data32 !== 32'h0000_0080) begin
            failed++;
            $display("FAIL lbu got wn=%b data=%h want wn=0 data=00000080", write_n32, data32);
        end
        in_valid = 1'b0; d_valid = 1'b0;
        step();
        tests_run++;
        if (write_n32 !== 1'b1 || qd32.size() != 0) begin
            failed++;
            $display("FAIL load_imm_end got wn=%b pending=%0d want wn=1 pending=0", write_n32, qd32.size());
        end
    endtask

    task automatic test_load_wait();
        logic [63:0] r0;
        r0 = retired32;
        opcode = LOAD; funct3 = 3'b001; rd = 5'd7; c = 64'h2; d = 64'hDEAD_BEEF;
        d_valid = 1'b0; in_valid = 1'b1;
        step();
        // in_valid left high with a different instruction: must be ignored while waiting
        opcode = OP; rd = 5'd12; c = 64'h5;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                in_valid = 1'b0;
                d_valid  = 1'b1;
                d        = 64'h8001_0000;
                qa32.push_back(5'd7); qd32.push_back(32'hFFFF_8001);
            end
            tests_run++;
            if (busy32 !== 1'b1 || in_ready32 !== 1'b0 || write_n32 !== 1'b1) begin
                failed++;
                $display("FAIL wait_cycle[%0d] got busy=%b rdy=%b wn=%b want 1,0,1",
                         k, busy32, in_ready32, write_n32);
            end
            if (k < 3) step();
        end
        step();
        d_valid = 1'b0;
        tests_run++;
        if (write_n32 !== 1'b0 || data32 !== 32'hFFFF_8001 || wr_addr32 !== 5'd7) begin
            failed++;
            $display("FAIL lh_late got wn=%b addr=%0d data=%h want wn=0 addr=7 data=ffff8001",
                     write_n32, wr_addr32, data32);
        end
        tests_run++;
        if (busy32 !== 1'b0 || in_ready32 !== 1'b1 || retired32 !== r0 + 64'd1) begin
            failed++;
            $display("FAIL lh_late_ctrl got busy=%b rdy=%b ret=%0d want 0,1,%0d",
                     busy32, in_ready32, retired32, r0 + 64'd1);
        end
        step();
        tests_run++;
        if (write_n32 !== 1'b1 || retired32 !== r0 + 64'd1 || qd32.size() != 0) begin
            failed++;
            $display("FAIL lh_late_end got wn=%b ret=%0d pending=%0d want 1,%0d,0",
                     write_n32, retired32, qd32.size(), r0 + 64'd1);
        end
    endtask

    task automatic test_reset_wait();
        opcode = LOAD; funct3 = 3'b001; rd = 5'd9; c = 64'h0; d_valid = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (busy32 !== 1'b1) begin
            failed++;
            $display("FAIL rstwait_enter got busy=%b want 1", busy32);
        end
        rst = 1'b1; d_valid = 1'b1; d = 64'h1234_5678;
        step();
        rst = 1'b0; d_valid = 1'b0;
        tests_run++;
        if (write_n32 !== 1'b1 || retired32 !== 64'd0 || in_ready32 !== 1'b1 || busy32 !== 1'b0) begin
            failed++;
            $display("FAIL rstwait got wn=%b ret=%0d rdy=%b busy=%b want 1,0,1,0",
                     write_n32, retired32, in_ready32, busy32);
        end
        step();
        tests_run++;
        if (write_n32 !== 1'b1 || data32 !== 32'd0) begin
            failed++;
            $display("FAIL rstwait_after got wn=%b data=%h want wn=1 data=0", write_n32, data32);
        end
    endtask

    task automatic test_nowrite();
        logic [6:0]  ops[4] = '{OP, LOAD, LOAD, JAL};
        logic [2:0]  f3s[4] = '{3'b000, 3'b110, 3'b111, 3'b000};
        logic [4:0]  rds[4] = '{5'd0, 5'd4, 5'd4, 5'd1};
        c = 64'h0; d = 64'hFFFF_FFFF; d_valid = 1'b1; pc = 64'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i]; funct3 = f3s[i]; rd = rds[i]; in_valid = 1'b1;
            if (i == 3) begin
                qa32.push_back(5'd1); qd32.push_back(32'd0);
            end
            step();
            tests_run++;
            if (write_n32 !== (i == 3 ? 1'b0 : 1'b1)) begin
                failed++;
                $display("FAIL nowrite[%0d] got wn=%b want %b", i, write_n32, (i == 3 ? 1'b0 : 1'b1));
            end
        end
        in_valid = 1'b0; d_valid = 1'b0;
        step();
        tests_run++;
        if (data32 !== 32'd0 || retired32 !== 64'd4 || qd32.size() != 0) begin
            failed++;
            $display("FAIL nowrite_end got data=%h ret=%0d pending=%0d want 0,4,0",
                     data32, retired32, qd32.size());
        end
    endtask

    task automatic test_xlen64();
        logic [2:0]  f3s[3] = '{3'b010, 3'b110, 3'b011};
        logic [63:0] cs[3]  = '{64'h0, 64'h0, 64'h4};
        logic [63:0] ds[3]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                                64'h1122_3344_5566_7788};
        logic [63:0] ex[3]  = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
                                64'h0000_0000_1122_3344};
        opcode = LOAD; rd = 5'd9; d_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            funct3 = f3s[i]; c = cs[i]; d = ds[i]; in_valid64 = 1'b1;
            qa64.push_back(5'd9); qd64.push_back(ex[i]);
            step();
            tests_run++;
            if (write_n64 !== 1'b0 || data64 !== ex[i]) begin
                failed++;
                $display("FAIL x64_load[%0d] got wn=%b data=%h want wn=0 data=%h",
                         i, write_n64, data64, ex[i]);
            end
        end
        in_valid64 = 1'b0; d_valid = 1'b0;
        step();
        tests_run++;
        if (write_n64 !== 1'b1 || retired64 !== 64'd3 || qd64.size() != 0 || write_n32 !== 1'b1) begin
            failed++;
            $display("FAIL x64_end got wn=%b ret=%0d pending=%0d wn32=%b want 1,3,0,1",
                     write_n64, retired64, qd64.size(), write_n32);
        end
    endtask

    initial begin
        test_reset();
        test_opclass();
        test_load_imm();
        test_load_wait();
        test_reset_wait();
        test_nowrite();
        test_xlen64();
        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
